// File: rtl/i2c_cfg_slave.sv
// Write-only I2C responder: oversamples SCL/SDA, ACKs its own write address,
// takes a register pointer and streams data bytes out as one-cycle write strobes.
module i2c_cfg_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'b1110110,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       SCL,
    inout  wire        SDA,
    output logic       Reg_wr,
    output logic [7:0] Reg_addr,
    output logic [7:0] Reg_data,
    output logic       Busy,
    output logic [7:0] Bytes_rx,
    output logic [2:0] fsm_state
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_REG      = 3'd3;
    localparam logic [2:0] ST_REG_ACK  = 3'd4;
    localparam logic [2:0] ST_DATA     = 3'd5;
    localparam logic [2:0] ST_DATA_ACK = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_rise;
    logic                   scl_fall;
    logic                   start_det;
    logic                   stop_det;

    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] byte_next;
    logic       sda_oe;

    // Synchronizers idle high so leaving reset on an idle bus produces no edges.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_next = {shift[6:0], sda_s};

    // Open-drain output; sda_oe has an async reset so the line frees instantly.
    assign SDA       = sda_oe ? 1'b0 : 1'bz;
    assign fsm_state = state;

    // In the ACK states sda_oe doubles as the phase flag: low until the 8th
    // SCL fall, high until the 9th fall, which ends the slot.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            sda_oe   <= 1'b0;
            Reg_wr   <= 1'b0;
            Reg_addr <= 8'd0;
            Reg_data <= 8'd0;
            Busy     <= 1'b0;
            Bytes_rx <= 8'd0;
        end else begin
            Reg_wr <= 1'b0;
            if (start_det) begin
                state   <= ST_ADDR;
                bit_cnt <= 3'd0;
                Busy    <= 1'b1;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state   <= ST_IDLE;
                bit_cnt <= 3'd0;
                Busy    <= 1'b0;
                sda_oe  <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR, ST_REG, ST_DATA: begin
                        if (scl_rise) begin
                            shift   <= byte_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (state == ST_ADDR) begin
                                    state <= (byte_next == {SLAVE_ADDR, 1'b0}) ? ST_ADDR_ACK : ST_IGNORE;
                                end else if (state == ST_REG) begin
                                    Reg_addr <= byte_next;
                                    state    <= ST_REG_ACK;
                                end else begin
                                    Reg_data <= byte_next;
                                    Reg_wr   <= 1'b1;
                                    if (Bytes_rx != 8'hFF) begin
                                        Bytes_rx <= Bytes_rx + 8'd1;
                                    end
                                    state <= ST_DATA_ACK;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                                if (state == ST_ADDR_ACK) begin
                                    Bytes_rx <= 8'd0;
                                    state    <= ST_REG;
                                end else if (state == ST_REG_ACK) begin
                                    state <= ST_DATA;
                                end else begin
                                    Reg_addr <= Reg_addr + 8'd1;
                                    state    <= ST_DATA;
                                end
                            end
                        end
                    end
                    default: begin
                        sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_cfg_slave.sv
// Directed bench for i2c_cfg_slave: a bit-banged I2C master drives transactions and
// captured write strobes are compared against a hand-written expected queue.
module tb_i2c_cfg_slave;

    localparam int Q = 100;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic       clk;
    logic       rst_n;
    logic       scl_m;
    logic       sda_m;
    wire        sda;
    logic       reg_wr;
    logic [7:0] reg_addr;
    logic [7:0] reg_data;
    logic       busy;
    logic [7:0] bytes_rx;
    logic [2:0] fsm_state;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_double = 0;
    logic wr_prev = 1'b0;
    logic ack;

    // Entries are {Bytes_rx, Reg_addr, Reg_data} captured at each strobe.
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];

    assign sda = sda_m ? 1'bz : 1'b0;
    pullup (sda);

    i2c_cfg_slave dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .SCL       (scl_m),
        .SDA       (sda),
        .Reg_wr    (reg_wr),
        .Reg_addr  (reg_addr),
        .Reg_data  (reg_data),
        .Busy      (busy),
        .Bytes_rx  (bytes_rx),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe monitor
    always @(negedge clk) begin
        if (reg_wr) begin
            got_q.push_back({bytes_rx, reg_addr, reg_data});
            if (wr_prev) wr_double++;
        end
        wr_prev = reg_wr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_sb(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            check({tag, "_strobe"}, got_q.pop_front(), exp_q.pop_front());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // driver tasks
    task automatic i2c_start();
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        sda_m = 1'b1; #Q;
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        a = sda;      #Q;
        scl_m = 1'b0; #Q;
    endtask

    initial begin
        rst_n = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        #Q;

        check("rst_wr", reg_wr, 0);
        check("rst_addr", reg_addr, 8'h00);
        check("rst_data", reg_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_bytes", bytes_rx, 8'h00);
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_sda", sda, 1'b1);

        // single write 0x49 <= 0xC0
        i2c_start();
        check("t1_busy", busy, 1);
        send_byte(8'hEC, ack); check("t1_ack_addr", ack, 0);
        send_byte(8'h49, ack); check("t1_ack_reg", ack, 0);
        send_byte(8'hC0, ack); check("t1_ack_data", ack, 0);
        i2c_stop();
        exp_q.push_back({8'd1, 8'h49, 8'hC0});
        check_sb("t1");
        check("t1_bytes", bytes_rx, 8'd1);
        check("t1_busy_end", busy, 0);

        // burst of three from 0x33
        i2c_start();
        send_byte(8'hEC, ack); check("t2_ack_addr", ack, 0);
        send_byte(8'h33, ack); check("t2_ack_reg", ack, 0);
        send_byte(8'h08, ack); check("t2_ack_d0", ack, 0);
        send_byte(8'h16, ack); check("t2_ack_d1", ack, 0);
        send_byte(8'h60, ack); check("t2_ack_d2", ack, 0);
        i2c_stop();
        exp_q.push_back({8'd1, 8'h33, 8'h08});
        exp_q.push_back({8'd2, 8'h34, 8'h16});
        exp_q.push_back({8'd3, 8'h35, 8'h60});
        check_sb("t2");
        check("t2_bytes", bytes_rx, 8'd3);

        // foreign address 0x50 write
        i2c_start();
        send_byte(8'hA0, ack); check("t3_nack_addr", ack, 1);
        check("t3_state", fsm_state, ST_IGNORE);
        send_byte(8'h12, ack); check("t3_nack_byte", ack, 1);
        check("t3_state_hold", fsm_state, ST_IGNORE);
        i2c_stop();
        check("t3_state_idle", fsm_state, ST_IDLE);
        check_sb("t3");

        // own address with rw=1
        i2c_start();
        send_byte(8'hED, ack); check("t4_nack_read", ack, 1);
        check("t4_state", fsm_state, ST_IGNORE);
        send_byte(8'h55, ack); check("t4_nack_byte", ack, 1);
        i2c_stop();
        check("t4_busy", busy, 0);
        check_sb("t4");

        // STOP after five data bits, then a clean write
        i2c_start();
        send_byte(8'hEC, ack);
        send_byte(8'h10, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        i2c_stop();
        check("t5_busy", busy, 0);
        check_sb("t5_partial");
        i2c_start();
        send_byte(8'hEC, ack);
        send_byte(8'h10, ack);
        send_byte(8'h5A, ack); check("t5_ack_data", ack, 0);
        i2c_stop();
        exp_q.push_back({8'd1, 8'h10, 8'h5A});
        check_sb("t5");

        // repeated START after reg byte 0x21
        i2c_start();
        send_byte(8'hEC, ack);
        send_byte(8'h21, ack);
        i2c_start();
        check("t6_busy_rs", busy, 1);
        send_byte(8'hEC, ack); check("t6_ack_addr", ack, 0);
        check("t6_ptr_kept", reg_addr, 8'h21);
        send_byte(8'h36, ack);
        send_byte(8'hA0, ack);
        i2c_stop();
        exp_q.push_back({8'd1, 8'h36, 8'hA0});
        check_sb("t6");

        // pointer wrap 0xFF -> 0x00
        i2c_start();
        send_byte(8'hEC, ack);
        send_byte(8'hFF, ack);
        send_byte(8'h11, ack);
        send_byte(8'h22, ack);
        i2c_stop();
        exp_q.push_back({8'd1, 8'hFF, 8'h11});
        exp_q.push_back({8'd2, 8'h00, 8'h22});
        check_sb("t7");
        check("t7_ptr_after", reg_addr, 8'h01);

        // reset while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : 8'hEC >> i & 1);
        sda_m = 1'b1; #Q;
        check("t8_ack_driven", sda, 1'b0);
        check("t8_state_ack", fsm_state, ST_ADDR_ACK);
        rst_n = 1'b0;
        #1;
        check("t8_sda_released", sda, 1'b1);
        check("t8_busy", busy, 0);
        check("t8_addr", reg_addr, 8'h00);
        check("t8_data", reg_data, 8'h00);
        check("t8_bytes", bytes_rx, 8'h00);
        check("t8_state", fsm_state, ST_IDLE);
        #Q;
        scl_m = 1'b1; #Q;
        @(negedge clk);
        rst_n = 1'b1;
        #Q;
        i2c_start();
        send_byte(8'hEC, ack); check("t8_ack_after", ack, 0);
        send_byte(8'h01, ack);
        send_byte(8'h99, ack);
        i2c_stop();
        exp_q.push_back({8'd1, 8'h01, 8'h99});
        check_sb("t8");

        check("strobe_width", wr_double, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_cfg_slave.md
Name: i2c_cfg_slave

Overview:
- I2C write-only responder (slave) for the register-configuration link, used in the bench model of the DVI transmitter and in on-chip peripherals configured over I2C.
- Oversamples the raw SDA/SCL lines on the system clock and detects START/STOP conditions.
- Decodes the address byte and ACKs its own write address, then takes a register-pointer byte followed by one or more data bytes.
- Each data byte is presented as a one-cycle register write strobe; the register pointer auto-increments.

Parameters:
- SLAVE_ADDR, 7'b1110110, 7-bit I2C address this block responds to.
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs (minimum 2).

Ports:
- Clk  input  1  system clock (≥ 8× SCL frequency).
- Reset_n  input  1  asynchronous, active-low reset.
- SCL  input  1  raw I2C clock.
- SDA  inout  1  I2C data; the block drives only '0' (open-drain) or 'z'.
- Reg_wr  output  1  one-cycle write strobe.
- Reg_addr  output  8  register address for the current strobe.
- Reg_data  output  8  data byte for the current strobe.
- Busy  output  1  high from an accepted START until STOP/abort.
- Bytes_rx  output  8  data bytes written in the current transaction; saturates at 255.

Behaviour:
- Reset values: Reg_wr=0, Reg_addr=0, Reg_data=0, Busy=0, Bytes_rx=0, SDA released ('z'), state IDLE, bit_cnt=0.
- Reset is effective at any time, including mid-transaction; SDA releases immediately (asynchronously).
- Input conditioning:
  - SCL and SDA each pass through SYNC_STAGES flops, plus one extra flop for edge detection.
  - scl_rise/scl_fall = edge of the synchronized SCL.
  - START = synchronized SDA falls while synchronized SCL is high.
  - STOP = synchronized SDA rises while synchronized SCL is high.
- Sampling and bit order: data is sampled on scl_rise, MSB first; bit_cnt runs 0..7.
- ACK slot: after the 8th scl_fall of an ACKed byte, SDA is driven low. It is released on the following (9th) scl_fall.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: START → ADDR, bit_cnt=0, Busy=1.
- ADDR: after 8 bits, the byte is compared as {addr[6:0], rw}.
  - Match with rw=0 → ADDR_ACK.
  - Address mismatch or rw=1 → IGNORE; no ACK is driven (SDA stays 'z'), so reads are NACKed.
- ADDR_ACK → REG on the 9th scl_fall; Bytes_rx is cleared at this point.
- REG: after 8 bits, the pointer is loaded into Reg_addr → REG_ACK → DATA on the 9th scl_fall.
- DATA:
  - After the 8th bit, Reg_data is loaded and Reg_wr pulses high for exactly 1 Clk, 1 cycle after that scl_rise is detected.
  - Reg_addr is stable during the strobe.
  - Bytes_rx increments in the same cycle as the strobe.
  - Then → DATA_ACK → DATA on the 9th scl_fall.
  - Reg_addr increments (wraps 0xFF→0x00) on the 9th scl_fall after each data byte.
- IGNORE: waits for START or STOP without driving SDA.
- STOP in any state → IDLE, Busy=0, SDA released; a partial byte is discarded with no strobe.
- Repeated START in any non-IDLE state → ADDR; bit_cnt=0; Reg_addr is kept until the new REG byte.
- START/STOP take priority over a scl edge detected in the same cycle.
- An ACK is also released if STOP/START is seen while SDA is driven, so the block never holds SDA low outside an ACK slot.
- The master may ignore the ACK; behaviour must not depend on SDA being read back during the ACK slot.

Test Plan:
- Write 0x76 address, reg 0x49, data 0xC0, STOP → ACK low on 3 slots; one Reg_wr with Reg_addr=0x49, Reg_data=0xC0; Bytes_rx=1; Busy falls after STOP.
- Burst: reg 0x33, data 0x08, 0x16, 0x60 → three strobes at addr 0x33/0x34/0x35 with matching data; Bytes_rx=3.
- Address 0x50 write and address 0x76 with rw=1 → SDA never driven low, no Reg_wr, state IGNORE until STOP.
- STOP after 5 data bits → no Reg_wr, Busy=0, next valid transaction writes correctly.
- Repeated START after the reg byte 0x21, new transaction reg 0x36 data 0xA0 → single strobe at 0x36=0xA0; pointer wrap check: reg 0xFF with two data bytes → strobes at 0xFF and 0x00.
- Reset_n asserted while SDA is driven low in an ACK slot → SDA 'z' immediately, all outputs at reset values.
